sweep_scheduler: RTL and testbench

- Sequences one full light-search sweep for the tracker: steps the panel through a theta × phi grid, waits for mechanical settling, and requests one ADC sample per grid point.
- Keeps the running maximum voltage and the angle pair where it occurred, then parks the panel at that best angle.
- Sits between the ADC sample interface and the servo angle drivers.
- Feeds best voltage/angles to the 7-segment display path.

---
 rtl/tracker_pkg.sv | 32 +++
 rtl/down_counter.sv | 37 +++
 rtl/sweep_scheduler.sv | 196 +++++++++++++++++++
 tb/tb_sweep_scheduler.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tracker_pkg.sv
// ============================================================================
//  Module      : tracker_pkg
//  Description : Shared types and constants for the light-tracker sweep logic.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tracker_pkg;

    // ADC sample width
    localparam int ADC_W = 12;

    // Default angle range and grid increment (degrees)
    localparam int DEF_ANGLE_W   = 8;
    localparam int DEF_THETA_MAX = 180;
    localparam int DEF_PHI_MAX   = 90;
    localparam int DEF_STEP      = 10;

    // Sweep sequencer states
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_MOVE   = 3'd1,
        S_SAMPLE = 3'd2,
        S_WAIT   = 3'd3,
        S_STEP   = 3'd4,
        S_PARK   = 3'd5,
        S_DONE   = 3'd6
    } state_e;

endpackage

`default_nettype wire

// File: rtl/down_counter.sv
// ============================================================================
//  Module      : down_counter
//  Description : Loadable down counter that stops at zero. Used for both the
//                servo settle delay and the ADC response timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module down_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             en_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] count_q;

    // Load wins over counting; the count parks at zero until reloaded
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (en_i && (count_q != '0)) begin
            count_q <= count_q - WIDTH'(1);
        end
    end

    assign zero_o = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/sweep_scheduler.sv
// ============================================================================
//  Module      : sweep_scheduler
//  Description : Steps the panel over a theta x phi grid, samples the ADC at
//                each point, tracks the maximum voltage and its angles, then
//                parks the panel at the best angle.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sweep_scheduler
    import tracker_pkg::*;
#(
    parameter int ANGLE_W       = DEF_ANGLE_W,
    parameter int THETA_MAX     = DEF_THETA_MAX,
    parameter int PHI_MAX       = DEF_PHI_MAX,
    parameter int STEP          = DEF_STEP,
    parameter int SETTLE_CYCLES = 50000,
    parameter int ADC_TIMEOUT   = 1024
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               adc_req,
    input  logic               adc_valid,
    input  logic [ADC_W-1:0]   adc_data,
    output logic [ANGLE_W-1:0] theta,
    output logic [ANGLE_W-1:0] phi,
    output logic               busy,
    output logic               done,
    output logic [ADC_W-1:0]   best_v,
    output logic [ANGLE_W-1:0] best_theta,
    output logic [ANGLE_W-1:0] best_phi,
    output logic [7:0]         timeout_cnt
);

    localparam int SET_W = $clog2(SETTLE_CYCLES) + 1;
    localparam int TO_W  = $clog2(ADC_TIMEOUT) + 1;

    // Counters are loaded with N-1 so the owning state lasts exactly N cycles
    localparam logic [SET_W-1:0]  C_SETTLE_LOAD = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [TO_W-1:0]   C_TO_LOAD     = TO_W'(ADC_TIMEOUT - 1);

    // Angle arithmetic is one bit wider than the outputs so the limit test never wraps
    localparam logic [ANGLE_W:0]  C_STEP      = (ANGLE_W+1)'(STEP);
    localparam logic [ANGLE_W:0]  C_THETA_MAX = (ANGLE_W+1)'(THETA_MAX);
    localparam logic [ANGLE_W:0]  C_PHI_MAX   = (ANGLE_W+1)'(PHI_MAX);

    state_e             state_q;
    logic               adc_req_q;
    logic               busy_q;
    logic               done_q;
    logic [ANGLE_W-1:0] theta_q;
    logic [ANGLE_W-1:0] phi_q;
    logic [ADC_W-1:0]   best_v_q;
    logic [ANGLE_W-1:0] best_theta_q;
    logic [ANGLE_W-1:0] best_phi_q;
    logic [7:0]         timeout_cnt_q;

    logic               w_settle_load;
    logic               w_settle_en;
    logic               w_settle_zero;
    logic               w_to_load;
    logic               w_to_en;
    logic               w_to_zero;
    logic [ANGLE_W:0]   w_theta_sum;
    logic [ANGLE_W:0]   w_phi_sum;

    // Settle delay restarts on every angle change: sweep start and every STEP exit
    assign w_settle_load = ((state_q == S_IDLE) && start) || (state_q == S_STEP);
    assign w_settle_en   = (state_q == S_MOVE) || (state_q == S_PARK);
    assign w_to_load     = (state_q == S_SAMPLE);
    assign w_to_en       = (state_q == S_WAIT);

    assign w_theta_sum = {1'b0, theta_q} + C_STEP;
    assign w_phi_sum   = {1'b0, phi_q} + C_STEP;

    down_counter #(
        .WIDTH      (SET_W)
    ) u_settle_cnt (
        .clk        (clk),
        .reset      (reset),
        .load_i     (w_settle_load),
        .load_val_i (C_SETTLE_LOAD),
        .en_i       (w_settle_en),
        .zero_o     (w_settle_zero)
    );

    down_counter #(
        .WIDTH      (TO_W)
    ) u_timeout_cnt (
        .clk        (clk),
        .reset      (reset),
        .load_i     (w_to_load),
        .load_val_i (C_TO_LOAD),
        .en_i       (w_to_en),
        .zero_o     (w_to_zero)
    );

    // Sweep sequencer with registered outputs and inline max capture
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            adc_req_q     <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            theta_q       <= '0;
            phi_q         <= '0;
            best_v_q      <= '0;
            best_theta_q  <= '0;
            best_phi_q    <= '0;
            timeout_cnt_q <= '0;
        end else begin
            adc_req_q <= 1'b0;
            done_q    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        best_v_q      <= '0;
                        best_theta_q  <= '0;
                        best_phi_q    <= '0;
                        timeout_cnt_q <= '0;
                        theta_q       <= '0;
                        phi_q         <= '0;
                        busy_q        <= 1'b1;
                        state_q       <= S_MOVE;
                    end
                end
                S_MOVE: begin
                    if (w_settle_zero) begin
                        adc_req_q <= 1'b1;
                        state_q   <= S_SAMPLE;
                    end
                end
                S_SAMPLE: begin
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    // A sample arriving on the expiry cycle still counts
                    if (adc_valid) begin
                        if (adc_data > best_v_q) begin
                            best_v_q     <= adc_data;
                            best_theta_q <= theta_q;
                            best_phi_q   <= phi_q;
                        end
                        state_q <= S_STEP;
                    end else if (w_to_zero) begin
                        if (timeout_cnt_q != 8'hFF) begin
                            timeout_cnt_q <= timeout_cnt_q + 8'd1;
                        end
                        state_q <= S_STEP;
                    end
                end
                S_STEP: begin
                    if (w_theta_sum <= C_THETA_MAX) begin
                        theta_q <= w_theta_sum[ANGLE_W-1:0];
                        state_q <= S_MOVE;
                    end else if (w_phi_sum <= C_PHI_MAX) begin
                        theta_q <= '0;
                        phi_q   <= w_phi_sum[ANGLE_W-1:0];
                        state_q <= S_MOVE;
                    end else begin
                        theta_q <= best_theta_q;
                        phi_q   <= best_phi_q;
                        state_q <= S_PARK;
                    end
                end
                S_PARK: begin
                    if (w_settle_zero) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign adc_req     = adc_req_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign theta       = theta_q;
    assign phi         = phi_q;
    assign best_v      = best_v_q;
    assign best_theta  = best_theta_q;
    assign best_phi    = best_phi_q;
    assign timeout_cnt = timeout_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_sweep_scheduler.sv
// ============================================================================
//  Module      : tb_sweep_scheduler
//  Description : Scoreboard bench for sweep_scheduler on small grids.
//                DUT A: THETA_MAX=20, PHI_MAX=10. DUT B: THETA_MAX=25.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sweep_scheduler;
    import tracker_pkg::*;

    typedef struct packed { logic [7:0] t; logic [7:0] p; } pt_t;
    typedef struct packed { logic [11:0] v; logic [7:0] t; logic [7:0] p; logic [7:0] tc; } res_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        start_b = 1'b0;
    logic        adc_valid = 1'b0;
    logic        adc_valid_b = 1'b0;
    logic [11:0] adc_data = '0;
    logic [11:0] adc_data_b = '0;

    logic        adc_req, busy, done, adc_req_b, busy_b, done_b;
    logic [7:0]  theta, phi, best_theta, best_phi, timeout_cnt;
    logic [7:0]  theta_b, phi_b, best_theta_b, best_phi_b, timeout_cnt_b;
    logic [11:0] best_v, best_v_b;

    pt_t  pt_q[$];
    pt_t  pt_qb[$];
    res_t res_q[$];
    res_t res_qb[$];

    int n_tests = 0;
    int n_fail  = 0;
    int n_req   = 0;
    int n_done  = 0;
    int n_done_b = 0;
    int mode    = 0;

    sweep_scheduler #(
        .ANGLE_W(8), .THETA_MAX(20), .PHI_MAX(10), .STEP(10),
        .SETTLE_CYCLES(3), .ADC_TIMEOUT(8)
    ) u_dut (
        .clk(clk), .reset(reset), .start(start), .adc_req(adc_req),
        .adc_valid(adc_valid), .adc_data(adc_data), .theta(theta), .phi(phi),
        .busy(busy), .done(done), .best_v(best_v), .best_theta(best_theta),
        .best_phi(best_phi), .timeout_cnt(timeout_cnt)
    );

    sweep_scheduler #(
        .ANGLE_W(8), .THETA_MAX(25), .PHI_MAX(10), .STEP(10),
        .SETTLE_CYCLES(3), .ADC_TIMEOUT(8)
    ) u_dut_b (
        .clk(clk), .reset(reset), .start(start_b), .adc_req(adc_req_b),
        .adc_valid(adc_valid_b), .adc_data(adc_data_b), .theta(theta_b), .phi(phi_b),
        .busy(busy_b), .done(done_b), .best_v(best_v_b), .best_theta(best_theta_b),
        .best_phi(best_phi_b), .timeout_cnt(timeout_cnt_b)
    );

    // Free-running clock
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input string what);
        n_tests++;
        n_fail++;
        $display("FAIL %s: %s", name, what);
    endtask

    task automatic push_grid(input int tmax, input int pmax, input bit to_b);
        pt_t e;
        for (int p = 0; p <= pmax; p += 10) begin
            for (int t = 0; t <= tmax; t += 10) begin
                e.t = 8'(t);
                e.p = 8'(p);
                if (to_b) pt_qb.push_back(e);
                else      pt_q.push_back(e);
            end
        end
    endtask

    task automatic push_res(input logic [11:0] v, input logic [7:0] t, input logic [7:0] p,
                            input logic [7:0] tc, input bit to_b);
        res_t r;
        r.v = v; r.t = t; r.p = p; r.tc = tc;
        if (to_b) res_qb.push_back(r);
        else      res_q.push_back(r);
    endtask

    // Returns on the falling edge of the cycle after the done pulse
    task automatic wait_done(input int prev, input bit on_b, input string name);
        int c = 0;
        while (((on_b ? n_done_b : n_done) == prev) && (c < 1000)) begin
            @(posedge clk);
            c++;
        end
        if ((on_b ? n_done_b : n_done) == prev)
            fail_now(name, $sformatf("got no done pulse in %0d cycles, expected one", c));
        @(negedge clk);
    endtask

    task automatic run_sweep(input int m, input logic [11:0] v, input logic [7:0] bt,
                             input logic [7:0] bp, input logic [7:0] tc, input string name);
        int prev = n_done;
        mode = m;
        push_grid(20, 10, 1'b0);
        push_res(v, bt, bp, tc, 1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({name, "_busy_rise"}, 32'(busy), 32'd1);
        wait_done(prev, 1'b0, name);
        check({name, "_done_width"}, 32'(done), 32'd0);
        check({name, "_busy_fall"}, 32'(busy), 32'd0);
        check({name, "_park_theta"}, 32'(theta), 32'(bt));
        check({name, "_park_phi"}, 32'(phi), 32'(bp));
    endtask

    // ADC model for DUT A: mode selects the returned value, latency is 2 cycles
    int          pend = 0;
    logic [7:0]  rt = '0;
    logic [7:0]  rp = '0;
    always @(negedge clk) begin
        adc_valid = 1'b0;
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                adc_valid = 1'b1;
                case (mode)
                    0:       adc_data = 12'(10 * int'(rt) + int'(rp));
                    1:       adc_data = 12'd500;
                    2:       adc_data = 12'd100;
                    default: adc_data = 12'd4095;
                endcase
            end
        end
        if (adc_req) begin
            rt = theta;
            rp = phi;
            pend = (mode == 2 && theta == 8'd10 && phi == 8'd0) ? 0 : 2;
        end
    end

    // ADC model for DUT B: value 10*theta+phi, latency 1 cycle
    int pend_b = 0;
    always @(negedge clk) begin
        adc_valid_b = 1'b0;
        if (pend_b > 0) begin
            pend_b--;
            if (pend_b == 0) adc_valid_b = 1'b1;
        end
        if (adc_req_b) begin
            adc_data_b = 12'(10 * int'(theta_b) + int'(phi_b));
            pend_b = 1;
        end
    end

    // Monitor for DUT A: compares each request and each done pulse to the scoreboard
    always @(negedge clk) begin
        pt_t  e;
        res_t r;
        if (adc_req) begin
            n_req++;
            if (pt_q.size() == 0) begin
                fail_now("req_unexpected", $sformatf("got request at %0d/%0d, expected none", theta, phi));
            end else begin
                e = pt_q.pop_front();
                check("req_theta", 32'(theta), 32'(e.t));
                check("req_phi", 32'(phi), 32'(e.p));
            end
        end
        if (done) begin
            n_done++;
            if (res_q.size() == 0) begin
                fail_now("done_unexpected", "got done pulse, expected none");
            end else begin
                r = res_q.pop_front();
                check("done_best_v", 32'(best_v), 32'(r.v));
                check("done_best_theta", 32'(best_theta), 32'(r.t));
                check("done_best_phi", 32'(best_phi), 32'(r.p));
                check("done_timeout_cnt", 32'(timeout_cnt), 32'(r.tc));
                check("done_theta", 32'(theta), 32'(r.t));
                check("done_phi", 32'(phi), 32'(r.p));
                check("done_busy", 32'(busy), 32'd1);
            end
        end
    end

    // Monitor for DUT B
    always @(negedge clk) begin
        pt_t  e;
        res_t r;
        if (adc_req_b) begin
            if (pt_qb.size() == 0) begin
                fail_now("b_req_unexpected", $sformatf("got request at %0d/%0d, expected none", theta_b, phi_b));
            end else begin
                e = pt_qb.pop_front();
                check("b_req_theta", 32'(theta_b), 32'(e.t));
                check("b_req_phi", 32'(phi_b), 32'(e.p));
            end
        end
        if (done_b) begin
            n_done_b++;
            if (res_qb.size() == 0) begin
                fail_now("b_done_unexpected", "got done pulse, expected none");
            end else begin
                r = res_qb.pop_front();
                check("b_done_best_v", 32'(best_v_b), 32'(r.v));
                check("b_done_best_theta", 32'(best_theta_b), 32'(r.t));
                check("b_done_best_phi", 32'(best_phi_b), 32'(r.p));
                check("b_done_theta", 32'(theta_b), 32'(r.t));
                check("b_done_phi", 32'(phi_b), 32'(r.p));
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    // Directed stimulus sequence
    initial begin
        int c;
        int prev;
        int req0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_adc_req", 32'(adc_req), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_theta", 32'(theta), 32'd0);
        check("rst_phi", 32'(phi), 32'd0);
        check("rst_best_v", 32'(best_v), 32'd0);
        check("rst_best_theta", 32'(best_theta), 32'd0);
        check("rst_best_phi", 32'(best_phi), 32'd0);
        check("rst_timeout_cnt", 32'(timeout_cnt), 32'd0);
        check("rst_b_busy", 32'(busy_b), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Ramp values: max at the last grid point
        run_sweep(0, 12'd210, 8'd20, 8'd10, 8'd0, "ramp");
        // All equal: first point keeps the best
        run_sweep(1, 12'd500, 8'd0, 8'd0, 8'd0, "ties");
        // No response at (10,0)
        run_sweep(2, 12'd100, 8'd0, 8'd0, 8'd1, "timeout");

        // Reset during the third WAIT, with a late 4095 sample afterwards
        mode = 3;
        push_grid(20, 10, 1'b0);
        req0 = n_req;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        c = 0;
        while ((n_req < req0 + 3) && (c < 500)) begin
            @(posedge clk);
            c++;
        end
        if (n_req < req0 + 3)
            fail_now("rst_mid_wait", $sformatf("got %0d requests, expected 3", n_req - req0));
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        pt_q.delete();
        check("midrst_adc_req", 32'(adc_req), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_theta", 32'(theta), 32'd0);
        check("midrst_phi", 32'(phi), 32'd0);
        check("midrst_best_v", 32'(best_v), 32'd0);
        check("midrst_best_theta", 32'(best_theta), 32'd0);
        check("midrst_best_phi", 32'(best_phi), 32'd0);
        check("midrst_timeout_cnt", 32'(timeout_cnt), 32'd0);
        @(negedge clk);
        check("midrst_idle_busy", 32'(busy), 32'd0);
        check("midrst_idle_best_v", 32'(best_v), 32'd0);

        run_sweep(0, 12'd210, 8'd20, 8'd10, 8'd0, "post_reset");

        // start held high: back-to-back sweeps, extra start toggles while busy
        mode = 0;
        push_grid(20, 10, 1'b0);
        push_grid(20, 10, 1'b0);
        push_res(12'd210, 8'd20, 8'd10, 8'd0, 1'b0);
        push_res(12'd210, 8'd20, 8'd10, 8'd0, 1'b0);
        prev = n_done;
        start = 1'b1;
        @(negedge clk);
        check("held_busy_rise", 32'(busy), 32'd1);
        wait_done(prev, 1'b0, "held_first");
        check("held_idle_busy", 32'(busy), 32'd0);
        check("held_idle_best_v", 32'(best_v), 32'd210);
        @(negedge clk);
        check("held_restart_busy", 32'(busy), 32'd1);
        check("held_restart_best_v", 32'(best_v), 32'd0);
        check("held_restart_best_theta", 32'(best_theta), 32'd0);
        check("held_restart_best_phi", 32'(best_phi), 32'd0);
        check("held_restart_theta", 32'(theta), 32'd0);
        check("held_restart_phi", 32'(phi), 32'd0);
        repeat (4) begin
            @(negedge clk);
            start = 1'b0;
            @(negedge clk);
            start = 1'b1;
        end
        prev = n_done;
        wait_done(prev, 1'b0, "held_second");
        start = 1'b0;
        check("held_end_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("held_no_retrigger", 32'(busy), 32'd0);

        // Non-multiple theta limit: 0,10,20 then wrap, never 30
        push_grid(25, 10, 1'b1);
        push_res(12'd210, 8'd20, 8'd10, 8'd0, 1'b1);
        prev = n_done_b;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        wait_done(prev, 1'b1, "b_sweep");
        check("b_busy_fall", 32'(busy_b), 32'd0);

        // Every expectation consumed
        check("pt_queue_empty", 32'(pt_q.size()), 32'd0);
        check("res_queue_empty", 32'(res_q.size()), 32'd0);
        check("b_pt_queue_empty", 32'(pt_qb.size()), 32'd0);
        check("b_res_queue_empty", 32'(res_qb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
